// File: rtl/pn_tx_pkg.sv
// ----------------------------------------------------------------------------
// pn_tx_pkg
// Shared definitions for the PN preamble transmitter and its LFSR core:
//   - state_t           : transmitter FSM states (IDLE / PREAMBLE / PAYLOAD)
//   - SC16_W            : width of one SC16 sample (I in [31:16], Q in [15:0])
//   - ORDER_MAX_DEFAULT : default maximum LFSR order
//   - bpsk_map()        : maps an LFSR output bit and magnitude to an SC16 word
// No ports (package).
// ----------------------------------------------------------------------------
package pn_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    localparam int SC16_W            = 32;
    localparam int ORDER_MAX_DEFAULT = 10;

    // A one bit maps to +magnitude on I, a zero bit to -magnitude (two's
    // complement); Q is always zero.
    function automatic logic [SC16_W-1:0] bpsk_map(input logic        i_bit,
                                                   input logic [14:0] i_mag);
        logic [15:0] w_pos;
        logic [15:0] w_neg;
        w_pos = {1'b0, i_mag};
        w_neg = 16'd0 - w_pos;
        return i_bit ? {w_pos, 16'h0000} : {w_neg, 16'h0000};
    endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// ----------------------------------------------------------------------------
// pn_lfsr_core
// Masked Fibonacci LFSR of runtime-selectable order (2..ORDER_MAX).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : capture seed (masked to the order), poly and order
//   i_advance   : step the register once
//   i_seed      : initial state (bits above the order are ignored)
//   i_poly      : feedback tap mask
//   i_order     : LFSR order
//   o_bit       : current output bit (state bit 0)
// Load and advance may be asserted together: the register then steps from the
// freshly masked seed, and o_bit already shows the seed's bit 0 in that cycle.
// ----------------------------------------------------------------------------
module pn_lfsr_core
    import pn_tx_pkg::*;
#(
    parameter int ORDER_MAX = ORDER_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_advance,
    input  logic [ORDER_MAX-1:0] i_seed,
    input  logic [ORDER_MAX-1:0] i_poly,
    input  logic [3:0]           i_order,
    output logic                 o_bit
);

    // (1 << order) - 1, built bitwise so it stays ORDER_MAX wide.
    function automatic logic [ORDER_MAX-1:0] order_mask(input logic [3:0] order);
        logic [ORDER_MAX-1:0] m;
        for (int i = 0; i < ORDER_MAX; i++) begin
            m[i] = (i < int'(order));
        end
        return m;
    endfunction

    // One-hot at position order-1, where the feedback bit is inserted.
    function automatic logic [ORDER_MAX-1:0] order_top(input logic [3:0] order);
        logic [ORDER_MAX-1:0] t;
        for (int i = 0; i < ORDER_MAX; i++) begin
            t[i] = (i == int'(order) - 1);
        end
        return t;
    endfunction

    logic [ORDER_MAX-1:0] r_state;
    logic [ORDER_MAX-1:0] r_poly;
    logic [ORDER_MAX-1:0] r_mask;
    logic [ORDER_MAX-1:0] r_top;

    logic [ORDER_MAX-1:0] w_load_mask;
    logic [ORDER_MAX-1:0] w_cur_state;
    logic [ORDER_MAX-1:0] w_cur_poly;
    logic [ORDER_MAX-1:0] w_cur_mask;
    logic [ORDER_MAX-1:0] w_cur_top;
    logic [ORDER_MAX-1:0] w_next_state;
    logic                 w_fb;

    // During a load the incoming configuration bypasses the registers so the
    // first bit and first step are available in the load cycle itself.
    assign w_load_mask  = order_mask(i_order);
    assign w_cur_state  = i_load ? (i_seed & w_load_mask) : r_state;
    assign w_cur_poly   = i_load ? i_poly                 : r_poly;
    assign w_cur_mask   = i_load ? w_load_mask            : r_mask;
    assign w_cur_top    = i_load ? order_top(i_order)     : r_top;

    assign w_fb         = ^(w_cur_state & w_cur_poly & w_cur_mask);
    assign w_next_state = (w_cur_state >> 1) | (w_fb ? w_cur_top : '0);
    assign o_bit        = w_cur_state[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_poly  <= '0;
            r_mask  <= '0;
            r_top   <= '0;
        end else begin
            if (i_load) begin
                r_poly <= i_poly;
                r_mask <= w_load_mask;
                r_top  <= order_top(i_order);
            end
            if (i_load || i_advance) begin
                r_state <= i_advance ? w_next_state : w_cur_state;
            end
        end
    end

endmodule

// File: rtl/pn_preamble_tx.sv
// ----------------------------------------------------------------------------
// pn_preamble_tx
// On a start pulse, emits a BPSK-mapped PN preamble (SC16) followed by one
// payload packet forwarded from the input stream, as a single AXIS packet.
// Ports:
//   ap_clk, ap_rst_n          : clock, asynchronous active-low reset
//   i_data_T*                 : payload input stream (SC16, with TLAST)
//   o_data_T*                 : output stream, one register stage
//   start_V                   : single-cycle start pulse
//   poly_V, seed_V, order_V   : LFSR taps, seed and order (latched at start)
//   pnseq_len_V               : preamble length in samples
//   amp_V                     : BPSK magnitude in bits [14:0]
//   busy                      : high whenever not IDLE
//   cfg_err                   : sticky, set by a start with an invalid order
// ----------------------------------------------------------------------------
module pn_preamble_tx
    import pn_tx_pkg::*;
#(
    parameter int ORDER_MAX    = ORDER_MAX_DEFAULT,
    parameter int LEN_W        = 10,
    parameter bit INSERT_TLAST = 1'b0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [SC16_W-1:0]    i_data_TDATA,
    input  logic                 i_data_TVALID,
    output logic                 i_data_TREADY,
    input  logic                 i_data_TLAST,
    output logic [SC16_W-1:0]    o_data_TDATA,
    output logic                 o_data_TVALID,
    input  logic                 o_data_TREADY,
    output logic                 o_data_TLAST,
    input  logic                 start_V,
    input  logic [ORDER_MAX-1:0] poly_V,
    input  logic [ORDER_MAX-1:0] seed_V,
    input  logic [3:0]           order_V,
    input  logic [LEN_W-1:0]     pnseq_len_V,
    input  logic [15:0]          amp_V,
    output logic                 busy,
    output logic                 cfg_err
);

    state_t            r_state;
    state_t            w_next_state;
    logic [LEN_W-1:0]  r_len_cnt;
    logic [LEN_W-1:0]  w_len_cnt_next;
    logic              w_len_cnt_we;
    logic [14:0]       r_amp;
    logic [14:0]       w_amp_mag;
    logic [SC16_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_cfg_err;

    logic              w_out_ready;
    logic              w_order_ok;
    logic              w_start_accept;
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic              w_lfsr_bit;
    logic              w_pre_beat;
    logic              w_pre_last;
    logic              w_pay_beat;
    logic              w_cfg_err_set;
    logic              w_unused_amp_msb;

    assign w_unused_amp_msb = amp_V[15];

    assign w_out_ready = !r_tvalid || o_data_TREADY;
    assign w_order_ok  = (order_V >= 4'd2) && (int'(order_V) <= ORDER_MAX);

    // The first preamble beat is built from the live amp input in the start
    // cycle; later beats use the latched copy.
    assign w_amp_mag   = (r_state == IDLE) ? amp_V[14:0] : r_amp;

    pn_lfsr_core #(
        .ORDER_MAX (ORDER_MAX)
    ) u_lfsr (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .i_load    (w_lfsr_load),
        .i_advance (w_lfsr_adv),
        .i_seed    (seed_V),
        .i_poly    (poly_V),
        .i_order   (order_V),
        .o_bit     (w_lfsr_bit)
    );

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and beat selection. A start accepted with a free output
    // register emits the first preamble beat immediately, so the output is
    // valid the cycle after the start and the count resumes from len-1.
    // The state leaves PREAMBLE/PAYLOAD in the cycle the last beat loads.
    always_comb begin
        w_next_state   = r_state;
        w_start_accept = 1'b0;
        w_lfsr_load    = 1'b0;
        w_lfsr_adv     = 1'b0;
        w_pre_beat     = 1'b0;
        w_pre_last     = 1'b0;
        w_pay_beat     = 1'b0;
        w_cfg_err_set  = 1'b0;
        w_len_cnt_we   = 1'b0;
        w_len_cnt_next = r_len_cnt;

        unique case (r_state)
            IDLE: begin
                if (start_V) begin
                    if (!w_order_ok) begin
                        w_cfg_err_set = 1'b1;
                    end else begin
                        w_start_accept = 1'b1;
                        w_lfsr_load    = 1'b1;
                        if (pnseq_len_V == '0) begin
                            w_next_state = INSERT_TLAST ? IDLE : PAYLOAD;
                        end else if (w_out_ready) begin
                            w_pre_beat     = 1'b1;
                            w_lfsr_adv     = 1'b1;
                            w_len_cnt_we   = 1'b1;
                            w_len_cnt_next = pnseq_len_V - LEN_W'(1);
                            if (pnseq_len_V == LEN_W'(1)) begin
                                w_pre_last   = 1'b1;
                                w_next_state = INSERT_TLAST ? IDLE : PAYLOAD;
                            end else begin
                                w_next_state = PREAMBLE;
                            end
                        end else begin
                            w_len_cnt_we   = 1'b1;
                            w_len_cnt_next = pnseq_len_V;
                            w_next_state   = PREAMBLE;
                        end
                    end
                end
            end
            PREAMBLE: begin
                if (w_out_ready) begin
                    w_pre_beat     = 1'b1;
                    w_lfsr_adv     = 1'b1;
                    w_len_cnt_we   = 1'b1;
                    w_len_cnt_next = r_len_cnt - LEN_W'(1);
                    if (r_len_cnt == LEN_W'(1)) begin
                        w_pre_last   = 1'b1;
                        w_next_state = INSERT_TLAST ? IDLE : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                w_pay_beat = i_data_TVALID && w_out_ready;
                if (w_pay_beat && i_data_TLAST) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Length counter, amplitude latch, sticky error and the output register.
    // TDATA/TLAST only change when a new beat loads, so they hold during stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len_cnt <= '0;
            r_amp     <= '0;
            r_cfg_err <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            if (w_len_cnt_we) begin
                r_len_cnt <= w_len_cnt_next;
            end
            if (w_start_accept) begin
                r_amp <= amp_V[14:0];
            end
            if (w_cfg_err_set) begin
                r_cfg_err <= 1'b1;
            end
            if (w_pre_beat) begin
                r_tdata  <= bpsk_map(w_lfsr_bit, w_amp_mag);
                r_tvalid <= 1'b1;
                r_tlast  <= INSERT_TLAST && w_pre_last;
            end else if (w_pay_beat) begin
                r_tdata  <= i_data_TDATA;
                r_tvalid <= 1'b1;
                r_tlast  <= i_data_TLAST;
            end else if (o_data_TREADY) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign i_data_TREADY = (r_state == PAYLOAD) && w_out_ready;
    assign o_data_TDATA  = r_tdata;
    assign o_data_TVALID = r_tvalid;
    assign o_data_TLAST  = r_tlast;
    assign busy          = (r_state != IDLE);
    assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_pn_preamble_tx.sv
// ----------------------------------------------------------------------------
// tb_pn_preamble_tx
// Drives two transmitters (one forwarding payload, one ending the packet on
// the last preamble sample) and checks their output streams against an
// expected-beat queue per instance.
// ----------------------------------------------------------------------------
module tb_pn_preamble_tx;

   logic        clk = 1'b0;
   logic        rstN;
   logic [31:0] inData;
   logic        inValid;
   logic        inLast;
   logic        noValid = 1'b0;
   logic        inReady0, inReady1;
   logic [31:0] tdata0, tdata1;
   logic        tvalid0, tvalid1, tlast0, tlast1;
   logic        oReady = 1'b1;
   logic        start0, start1;
   logic [9:0]  polyV, seedV, lenV;
   logic [3:0]  orderV;
   logic [15:0] ampV;
   logic        busy0, busy1, cfgErr0, cfgErr1;

   int checks = 0;
   int errors = 0;
   int preRemain0 = 0;
   bit randomReady = 1'b0;
   bit randomValid = 1'b0;

   // Expected beats: bit 33 = preamble beat, bit 32 = TLAST, [31:0] = TDATA.
   logic [33:0] q0[$];
   logic [33:0] q1[$];
   logic [32:0] payQ[$];

   logic [15:0] basicI [7] = '{16'h1000, 16'hF000, 16'hF000, 16'h1000,
                               16'hF000, 16'h1000, 16'h1000};

   always #5 clk = ~clk;

   pn_preamble_tx #(.ORDER_MAX(10), .LEN_W(10), .INSERT_TLAST(1'b0)) dut0 (
      .ap_clk(clk), .ap_rst_n(rstN),
      .i_data_TDATA(inData), .i_data_TVALID(inValid), .i_data_TREADY(inReady0),
      .i_data_TLAST(inLast),
      .o_data_TDATA(tdata0), .o_data_TVALID(tvalid0), .o_data_TREADY(oReady),
      .o_data_TLAST(tlast0),
      .start_V(start0), .poly_V(polyV), .seed_V(seedV), .order_V(orderV),
      .pnseq_len_V(lenV), .amp_V(ampV), .busy(busy0), .cfg_err(cfgErr0));

   pn_preamble_tx #(.ORDER_MAX(10), .LEN_W(10), .INSERT_TLAST(1'b1)) dut1 (
      .ap_clk(clk), .ap_rst_n(rstN),
      .i_data_TDATA(inData), .i_data_TVALID(noValid), .i_data_TREADY(inReady1),
      .i_data_TLAST(inLast),
      .o_data_TDATA(tdata1), .o_data_TVALID(tvalid1), .o_data_TREADY(oReady),
      .o_data_TLAST(tlast1),
      .start_V(start1), .poly_V(polyV), .seed_V(seedV), .order_V(orderV),
      .pnseq_len_V(lenV), .amp_V(ampV), .busy(busy1), .cfg_err(cfgErr1));

   // Single comparison point: counts every check and reports each failure.
   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pulse start for one cycle on the selected instance.
   task automatic applyStimulus(input bit sel);
      @(posedge clk); #1;
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Known 7-periodic sequence for order 3, taps 011, seed 001, amp 0x1000.
   task automatic pushPattern(input bit sel, input int len, input bit lastOnFinal);
      logic [33:0] e;
      for (int k = 0; k < len; k++) begin
         e = {1'b1, lastOnFinal && (k == len - 1), basicI[k % 7], 16'h0000};
         if (sel) q1.push_back(e);
         else begin
            q0.push_back(e);
            preRemain0++;
         end
      end
   endtask

   // Reference preamble for dut0 computed directly from the sequence rules.
   task automatic modelPreamble(input int seed, input int poly, input int order,
                                input int len, input logic [15:0] amp);
      int s, mask, fb;
      logic [15:0] mag, iv;
      mask = (1 << order) - 1;
      s    = seed & mask;
      mag  = amp & 16'h7FFF;
      for (int k = 0; k < len; k++) begin
         iv = ((s & 1) != 0) ? mag : 16'(16'h0000 - mag);
         q0.push_back({1'b1, 1'b0, iv, 16'h0000});
         preRemain0++;
         fb = $countones(s & poly & mask) & 1;
         s  = (s >> 1) | (fb << (order - 1));
      end
   endtask

   task automatic pushPayloadWord(input logic [31:0] d, input bit last);
      payQ.push_back({last, d});
      q0.push_back({1'b0, last, d});
   endtask

   task automatic waitDrain(input string name, input int budget);
      bit idleNow;
      int n;
      n = 0;
      idleNow = 1'b0;
      while (!idleNow && n < budget) begin
         @(negedge clk);
         n++;
         idleNow = (q0.size() == 0) && (q1.size() == 0) && (payQ.size() == 0) &&
                   !tvalid0 && !tvalid1 && !busy0 && !busy1;
      end
      checkOutput(name, {63'd0, idleNow}, 64'd1);
   endtask

   // Output ready: always high, or a coin toss each cycle.
   initial begin
      forever begin
         @(posedge clk); #1;
         oReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Payload source for dut0: presents payQ head, holds it until accepted.
   initial begin
      bit hsIn;
      inValid = 1'b0; inData = '0; inLast = 1'b0;
      forever begin
         @(negedge clk);
         hsIn = inValid && inReady0;
         @(posedge clk); #1;
         if (hsIn && payQ.size() > 0) void'(payQ.pop_front());
         if (payQ.size() == 0) inValid = 1'b0;
         else if (inValid && !hsIn) inValid = 1'b1;
         else if (!randomValid || $urandom_range(0, 3) != 0) begin
            inValid = 1'b1;
            {inLast, inData} = payQ[0];
         end else inValid = 1'b0;
      end
   end

   // Monitor for dut0: scoreboard pop, stall stability, input-ready rule.
   logic        holdPending0 = 1'b0, heldLast0;
   logic [31:0] heldData0;
   always @(negedge clk) begin : monitor0
      logic [33:0] expv;
      if (!rstN) holdPending0 = 1'b0;
      else begin
         if (holdPending0)
            checkOutput("hold_stable0", {tvalid0, tlast0, tdata0}, {1'b1, heldLast0, heldData0});
         checkOutput("in_ready_in_preamble0",
                     {63'd0, inReady0 && (preRemain0 > (tvalid0 ? 1 : 0))}, 64'd0);
         if (tvalid0 && oReady) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL extra_beat0: got %h, expected no beat", tdata0);
            end else begin
               expv = q0.pop_front();
               if (expv[33]) preRemain0--;
               checkOutput("beat0", {tlast0, tdata0}, expv[32:0]);
            end
         end
         holdPending0 = tvalid0 && !oReady;
         heldData0    = tdata0;
         heldLast0    = tlast0;
      end
   end

   // Monitor for dut1.
   logic        holdPending1 = 1'b0, heldLast1;
   logic [31:0] heldData1;
   always @(negedge clk) begin : monitor1
      logic [33:0] expv;
      if (!rstN) holdPending1 = 1'b0;
      else begin
         if (holdPending1)
            checkOutput("hold_stable1", {tvalid1, tlast1, tdata1}, {1'b1, heldLast1, heldData1});
         if (tvalid1 && oReady) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("[TB] FAIL extra_beat1: got %h, expected no beat", tdata1);
            end else begin
               expv = q1.pop_front();
               checkOutput("beat1", {tlast1, tdata1}, expv[32:0]);
            end
         end
         holdPending1 = tvalid1 && !oReady;
         heldData1    = tdata1;
         heldLast1    = tlast1;
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gapCount;
      bit found;
      rstN = 1'b0; start0 = 1'b0; start1 = 1'b0;
      polyV = '0; seedV = '0; orderV = '0; lenV = '0; ampV = '0;

      // Reset state.
      repeat (3) @(posedge clk); #1;
      checkOutput("reset_outputs0", {tdata0, tvalid0, tlast0, busy0, cfgErr0, inReady0}, 64'd0);
      checkOutput("reset_outputs1", {tdata1, tvalid1, tlast1, busy1, cfgErr1, inReady1}, 64'd0);
      @(negedge clk); rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("idle_after_reset", {busy0, busy1, tvalid0, tvalid1}, 64'd0);

      // Basic preamble on the TLAST-inserting instance.
      $display("[TB] basic preamble");
      polyV = 10'b011; seedV = 10'b001; orderV = 4'd3; lenV = 10'd7; ampV = 16'h1000;
      pushPattern(1'b1, 7, 1'b1);
      applyStimulus(1'b1);
      checkOutput("first_beat_latency1", {63'd0, tvalid1}, 64'd1);
      waitDrain("drain_basic", 200);
      checkOutput("busy_after_basic1", {63'd0, busy1}, 64'd0);

      // Preamble followed by payload, no gap at the boundary.
      $display("[TB] preamble plus payload");
      lenV = 10'd14;
      pushPattern(1'b0, 14, 1'b0);
      pushPayloadWord(32'h11112222, 1'b0);
      pushPayloadWord(32'h33334444, 1'b0);
      pushPayloadWord(32'h55556666, 1'b1);
      applyStimulus(1'b0);
      gapCount = 0;
      repeat (17) begin
         @(negedge clk);
         if (tvalid0) gapCount++;
      end
      checkOutput("no_gap_valid_count0", 64'(gapCount), 64'd17);
      waitDrain("drain_payload", 200);

      // Backpressure plus an ignored start mid-preamble.
      $display("[TB] backpressure");
      randomReady = 1'b1;
      lenV = 10'd7;
      pushPattern(1'b1, 7, 1'b1);
      applyStimulus(1'b1);
      repeat (2) @(posedge clk);
      seedV = 10'b101;
      applyStimulus(1'b1);
      seedV = 10'b001;
      waitDrain("drain_backpressure", 400);
      checkOutput("cfg_err_after_ignored_start1", {63'd0, cfgErr1}, 64'd0);

      // Randomized configurations with payload and input gaps.
      $display("[TB] randomized packets");
      randomValid = 1'b1;
      for (int it = 0; it < 10; it++) begin
         int ord, pol, sd, ln, np;
         logic [15:0] amp;
         ord = $urandom_range(2, 10);
         pol = $urandom_range(0, 1023);
         sd  = $urandom_range(0, 1023);
         ln  = $urandom_range(0, 40);
         np  = $urandom_range(1, 5);
         amp = 16'($urandom_range(0, 65535));
         if (it == 0) sd = 0;
         orderV = 4'(ord); polyV = 10'(pol); seedV = 10'(sd); lenV = 10'(ln); ampV = amp;
         modelPreamble(sd, pol, ord, ln, amp);
         for (int k = 0; k < np; k++) pushPayloadWord($urandom, k == np - 1);
         applyStimulus(1'b0);
         orderV = 4'($urandom_range(2, 10));
         polyV  = 10'($urandom_range(0, 1023));
         ampV   = 16'($urandom_range(0, 65535));
         waitDrain("drain_random", 3000);
      end

      // Zero-length preamble: payload forwarded one cycle after handshake.
      $display("[TB] zero-length preamble");
      randomReady = 1'b0; randomValid = 1'b0;
      orderV = 4'd3; lenV = 10'd0;
      pushPayloadWord(32'hA5A5_0001, 1'b0);
      pushPayloadWord(32'hA5A5_0002, 1'b1);
      applyStimulus(1'b0);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         found = inValid && inReady0;
      end
      @(negedge clk);
      checkOutput("len0_payload_latency0", {62'd0, found, tvalid0}, 64'd3);
      waitDrain("drain_len0", 200);

      // Rejected starts for out-of-range orders.
      $display("[TB] rejected starts");
      lenV = 10'd7; orderV = 4'd1;
      applyStimulus(1'b1);
      repeat (3) @(negedge clk);
      checkOutput("reject_order1", {cfgErr1, busy1, tvalid1}, 64'b100);
      orderV = 4'd11;
      applyStimulus(1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reject_order11", {cfgErr0, busy0, tvalid0}, 64'b100);

      // Reset during beat 3, then the sequence restarts from the seed.
      $display("[TB] reset mid-preamble");
      orderV = 4'd3; polyV = 10'b011; seedV = 10'b001; lenV = 10'd7; ampV = 16'h1000;
      pushPattern(1'b1, 7, 1'b1);
      applyStimulus(1'b1);
      @(posedge clk);
      @(posedge clk); #2;
      rstN = 1'b0; #1;
      checkOutput("async_reset_outputs1", {tdata1, tvalid1, tlast1, busy1, cfgErr1, inReady1}, 64'd0);
      checkOutput("async_reset_outputs0", {tdata0, tvalid0, tlast0, busy0, cfgErr0, inReady0}, 64'd0);
      q0.delete(); q1.delete(); payQ.delete(); preRemain0 = 0;
      @(negedge clk); rstN = 1'b1;
      pushPattern(1'b1, 7, 1'b1);
      applyStimulus(1'b1);
      waitDrain("drain_after_reset", 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pn_preamble_tx.md
# pn_preamble_tx

PN-sequence preamble transmitter: on a start pulse it generates a BPSK-modulated LFSR sequence as SC16 samples and then forwards one payload packet from its input stream, all as a single AXI-Stream packet. It is the transmit-side counterpart of the PN correlator. It sits in the user-code section of a noc_block, between the axi_wrapper `m_axis_data` and `s_axis_data` ports. Its configuration comes from setting registers.

## Interface
- `ORDER_MAX`, 10: maximum LFSR order; also the width of the seed and polynomial inputs.
- `LEN_W`, 10: width of the preamble length.
- `INSERT_TLAST`, 0: 1 = the last preamble sample carries TLAST and no payload is forwarded.

Ports:
- `ap_clk` in 1: single clock.
- `ap_rst_n` in 1: reset, asynchronous, active-low.
- `i_data_TDATA` in 32: payload samples, SC16 (I in [31:16], Q in [15:0]).
- `i_data_TVALID` in 1, `i_data_TREADY` out 1, `i_data_TLAST` in 1: payload AXIS handshake.
- `o_data_TDATA` out 32, `o_data_TVALID` out 1, `o_data_TREADY` in 1, `o_data_TLAST` out 1: output AXIS.
- `start_V` in 1: single-cycle start pulse.
- `poly_V` in ORDER_MAX: feedback tap mask.
- `seed_V` in ORDER_MAX: initial LFSR state.
- `order_V` in 4: LFSR order; valid range 2..ORDER_MAX.
- `pnseq_len_V` in LEN_W: number of preamble samples.
- `amp_V` in 16: BPSK amplitude; bits [14:0] are used as an unsigned magnitude, bit 15 is ignored.
- `busy` out 1: high in any state other than IDLE.
- `cfg_err` out 1: sticky error flag, set when a start is rejected for an invalid order.

## Operation
- **States:** IDLE, PREAMBLE, PAYLOAD.
- **IDLE, on `start_V`:**
  - Latches poly, order, length and amp.
  - Computes `mask = (1<<order)-1` and loads `s = seed & mask`.
  - If order < 2 or order > ORDER_MAX: start is ignored and `cfg_err` is set.
  - If len = 0: goes directly to PAYLOAD (or to IDLE when INSERT_TLAST=1).
  - Otherwise: goes to PREAMBLE.
- **LFSR (Fibonacci form), advanced once per accepted preamble beat:**
  - Output bit `b = s[0]`.
  - `fb = ^(s & poly & mask)`.
  - `s_next = (s>>1) | (fb << (order-1))`.
- **Mapping:** b=1 gives I = +amp, b=0 gives I = -amp (two's complement); Q = 0 in both cases.
- **PREAMBLE:**
  - Emits exactly len beats.
  - After the final beat: goes to PAYLOAD, or to IDLE when INSERT_TLAST=1 (that final beat has TLAST=1).
  - When INSERT_TLAST=0, TLAST = 0 on all preamble beats.
- **PAYLOAD:**
  - Passes input beats through unchanged, including TLAST.
  - Returns to IDLE after forwarding the beat with TLAST=1.
- `start_V` while busy is ignored and does not set `cfg_err`.
- `cfg_err` clears only on reset.
- A seed of all zeros (after masking) is legal and produces a constant -amp preamble.

## Timing
- **Reset values:** every output 0; state IDLE; LFSR state 0. Reset asserted mid-packet aborts immediately with no TLAST emitted.
- **Output register:** one stage, AXIS compliant.
  - The register loads when `!o_data_TVALID || o_data_TREADY`.
  - TDATA and TLAST are held stable while TVALID=1 and TREADY=0.
- **Latency:**
  - First preamble beat: TVALID rises the cycle after `start_V` is sampled.
  - Payload: one cycle from the input handshake to output valid.
- **Throughput:** one beat per cycle at full TREADY, with no bubble at the PREAMBLE-to-PAYLOAD boundary.
- **Input ready:** `i_data_TREADY = (state==PAYLOAD) && (!o_data_TVALID || o_data_TREADY)`. It is 0 in all other states.
- **Last-beat boundary:** the state leaves PREAMBLE or PAYLOAD in the same cycle the last beat is loaded into the output register.
  - A new start is accepted from the cycle after state = IDLE.
  - The new first beat may load while the previous last beat is still being drained.
- **Length counter:** LEN_W wide, counts down from len to 1. The maximum length is 2^LEN_W - 1, with no wrap.
- **Order change:** order is latched at start. Changing `order_V` mid-packet has no effect until the next start.

## Structure
- Shared package `pn_tx_pkg` holds:
  - the state enum (IDLE/PREAMBLE/PAYLOAD);
  - `SC16_W=32`;
  - the ORDER_MAX default;
  - a function mapping (b, amp) to SC16.
- Sub-module `pn_lfsr_core` holds the masked Fibonacci LFSR, with load, advance, seed, poly and order inputs and the bit output. It is reusable by the receive side.
- The top level holds the FSM, length counter, output register and passthrough mux.

## Test plan
- **Basic preamble:** order=3, poly=3'b011, seed=3'b001, len=7, amp=0x1000, INSERT_TLAST=1, TREADY=1.
  - Output I = 1000, F000, F000, 1000, F000, 1000, 1000 with Q=0.
  - TLAST on beat 7; busy low afterwards.
- **Preamble plus payload:** same config with len=14, INSERT_TLAST=0, plus a 3-beat payload 0x11112222, 0x33334444, 0x55556666 (TLAST on the last).
  - The 7-beat pattern repeats twice, then the 3 payload beats follow with no gap.
  - Single TLAST on the final payload beat.
- **Backpressure:** toggle TREADY randomly.
  - The sequence is identical to the basic case.
  - TDATA is held stable during stalls.
  - `i_data_TREADY` never rises during PREAMBLE.
- **Rejected and ignored starts:**
  - order=1: `cfg_err`=1, no output, busy stays 0.
  - A start pulse mid-preamble is ignored and the beat count is unchanged.
- **len=0 with INSERT_TLAST=0:** the payload is forwarded immediately, first output TVALID one cycle after the input handshake.
- **Reset mid-operation:** deassert `ap_rst_n` during beat 3.
  - All outputs are 0 asynchronously.
  - A new start after reset reproduces the sequence from the seed.
